// File: rtl/shifter_pkg.sv
// Shared definitions for the barrel shifter family (left and right variants).
//   SHIFT_LOGICAL / SHIFT_ARITH : encodings of the ARITH mode input
//   stage_count()               : shift-amount width, which is also the number of
//                                 pipeline stages, for a given data width
package shifter_pkg;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

  // A log shifter needs one stage per shift-amount bit. Clamp at 1 so a
  // degenerate width still produces a legal shift port.
  function automatic int stage_count(input int data_width);
    return (data_width <= 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/n_right_shifter_pipe_if.sv
// Handshake bundle for the pipelined right barrel shifter.
//   Input side : IVALID, IREADY, IDATA, N_SHIFT, ARITH
//   Output side: OVALID, OREADY, ODATA
// master = the surrounding datapath (produces input words, consumes results)
// slave  = the shifter itself
interface n_right_shifter_pipe_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 3
);

  logic                   IVALID;
  logic                   IREADY;
  logic [DATA_WIDTH-1:0]  IDATA;
  logic [SHIFT_WIDTH-1:0] N_SHIFT;
  logic                   ARITH;
  logic                   OVALID;
  logic                   OREADY;
  logic [DATA_WIDTH-1:0]  ODATA;

  modport master (
    output IVALID, IDATA, N_SHIFT, ARITH, OREADY,
    input  IREADY, OVALID, ODATA
  );

  modport slave (
    input  IVALID, IDATA, N_SHIFT, ARITH, OREADY,
    output IREADY, OVALID, ODATA
  );

endinterface

// File: rtl/right_shift_stage.sv
// One registered stage of the log right shifter: conditionally shifts the
// incoming word right by N (a power of two), inserting the carried fill bit at
// the MSB end, and passes the remaining low shift bits and fill bit along.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : upstream handshake
//   in_data, in_shift, in_fill : upstream word, full shift amount, fill bit
//   out_valid/out_ready        : downstream handshake
//   out_data, out_shift, out_fill : registered word and side-band
module right_shift_stage
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 3,
  parameter int N           = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  input  logic                   in_fill,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_fill
);

  localparam int BIT = $clog2(N);
  // Only the shift bits below this stage matter further down; clearing the
  // consumed bits lets synthesis drop their flops.
  localparam logic [SHIFT_WIDTH-1:0] KEEP_MASK = SHIFT_WIDTH'((1 << BIT) - 1);

  logic                   vld_p0;
  logic [DATA_WIDTH-1:0]  data_p0;
  logic [SHIFT_WIDTH-1:0] shift_p0;
  logic                   fill_p0;
  logic [DATA_WIDTH-1:0]  data_shifted;

  // Right shift by N with fill. A shift of the full width or more leaves only
  // fill bits, so cumulative shifts saturate instead of wrapping.
  function automatic logic [DATA_WIDTH-1:0] shift_fill(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  f
  );
    logic [DATA_WIDTH-1:0] r;
    r = DATA_WIDTH'({{DATA_WIDTH{f}}, d} >> N);
    return (N >= DATA_WIDTH) ? {DATA_WIDTH{f}} : r;
  endfunction

  assign data_shifted = in_shift[BIT] ? shift_fill(in_data, in_fill) : in_data;

  // A stage can take a new word when empty or when its word leaves this cycle.
  assign in_ready = ~vld_p0 | out_ready;

  // Stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      shift_p0 <= '0;
      fill_p0  <= 1'b0;
    end else if (in_ready) begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        data_p0  <= data_shifted;
        shift_p0 <= in_shift & KEEP_MASK;
        fill_p0  <= in_fill;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_shift = shift_p0;
  assign out_fill  = fill_p0;

endmodule

// File: rtl/n_right_shifter_pipe.sv
// Pipelined logarithmic right barrel shifter (logical or arithmetic).
// One registered stage per shift-amount bit, largest shift first; latency is
// SHIFT_WIDTH cycles, throughput one word per cycle, full backpressure.
//   CLK   : clock
//   RST_N : asynchronous active-low reset, flushes every in-flight word
//   bus   : slave side of n_right_shifter_pipe_if
//           IVALID/IREADY/IDATA/N_SHIFT/ARITH in, OVALID/OREADY/ODATA out
module n_right_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = stage_count(DATA_WIDTH)
) (
  input logic                   CLK,
  input logic                   RST_N,
  n_right_shifter_pipe_if.slave bus
);

  // Index SHIFT_WIDTH is the pipe input, index 0 the pipe output; stage k
  // reads index k+1 and drives index k.
  logic [SHIFT_WIDTH:0]                         vld_bus;
  logic [SHIFT_WIDTH:0]                         rdy_bus;
  logic [SHIFT_WIDTH:0]                         fill_bus;
  logic [(SHIFT_WIDTH+1)*DATA_WIDTH-1:0]        data_bus;
  logic [(SHIFT_WIDTH+1)*SHIFT_WIDTH-1:0]       shift_bus;
  logic                                         unused_tail;

  assign vld_bus[SHIFT_WIDTH]                                     = bus.IVALID;
  assign data_bus[SHIFT_WIDTH*DATA_WIDTH +: DATA_WIDTH]           = bus.IDATA;
  assign shift_bus[SHIFT_WIDTH*SHIFT_WIDTH +: SHIFT_WIDTH]        = bus.N_SHIFT;
  // Sign bit is sampled once at entry and travels with the word.
  assign fill_bus[SHIFT_WIDTH] = (bus.ARITH == SHIFT_ARITH) & bus.IDATA[DATA_WIDTH-1];

  assign rdy_bus[0] = bus.OREADY;
  assign bus.IREADY = rdy_bus[SHIFT_WIDTH];
  assign bus.OVALID = vld_bus[0];
  assign bus.ODATA  = data_bus[DATA_WIDTH-1:0];

  // Fill and shift side-band have no consumer past the last stage.
  assign unused_tail = fill_bus[0] ^ (^shift_bus[SHIFT_WIDTH-1:0]);

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    // Stage k: conditional shift by 2^k
    right_shift_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH),
      .N           (1 << k)
    ) u_stage (
      .clk       (CLK),
      .rst_n     (RST_N),
      .in_valid  (vld_bus[k+1]),
      .in_ready  (rdy_bus[k+1]),
      .in_data   (data_bus[(k+1)*DATA_WIDTH +: DATA_WIDTH]),
      .in_shift  (shift_bus[(k+1)*SHIFT_WIDTH +: SHIFT_WIDTH]),
      .in_fill   (fill_bus[k+1]),
      .out_valid (vld_bus[k]),
      .out_ready (rdy_bus[k]),
      .out_data  (data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
      .out_shift (shift_bus[k*SHIFT_WIDTH +: SHIFT_WIDTH]),
      .out_fill  (fill_bus[k])
    );
  end

endmodule

// File: tb/tb_n_right_shifter_pipe.sv
// Directed bench for n_right_shifter_pipe: an 8-bit instance and a 6-bit
// instance (non-power-of-2 width) sharing clock and reset.
module tb_n_right_shifter_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  n_right_shifter_pipe_if #(.DATA_WIDTH(8), .SHIFT_WIDTH(3)) if8 ();
  n_right_shifter_pipe_if #(.DATA_WIDTH(6), .SHIFT_WIDTH(3)) if6 ();

  n_right_shifter_pipe #(.DATA_WIDTH(8), .SHIFT_WIDTH(3)) u_dut8 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (if8.slave)
  );

  n_right_shifter_pipe #(.DATA_WIDTH(6), .SHIFT_WIDTH(3)) u_dut6 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (if6.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] stream_exp [8] = '{8'h40, 8'h40, 8'h41, 8'h41, 8'h42, 8'h42, 8'h43, 8'h43};
  logic [7:0] bp_in      [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
  logic [7:0] bp_exp     [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  int idx;
  int outc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_odata(input bit w6);
    return w6 ? 32'(if6.ODATA) : 32'(if8.ODATA);
  endfunction

  function automatic logic [31:0] get_ovalid(input bit w6);
    return w6 ? 32'(if6.OVALID) : 32'(if8.OVALID);
  endfunction

  function automatic logic [31:0] get_iready(input bit w6);
    return w6 ? 32'(if6.IREADY) : 32'(if8.IREADY);
  endfunction

  // Offer one word, then confirm it appears exactly 3 cycles after acceptance.
  task automatic lat_run(input bit w6, input logic [31:0] d, input logic [31:0] s,
                         input logic a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    if (w6) begin
      if6.IVALID = 1'b1; if6.IDATA = d[5:0]; if6.N_SHIFT = s[2:0]; if6.ARITH = a;
    end else begin
      if8.IVALID = 1'b1; if8.IDATA = d[7:0]; if8.N_SHIFT = s[2:0]; if8.ARITH = a;
    end
    #1 check({tag, "_iready"}, get_iready(w6), 1);
    @(negedge clk);
    if6.IVALID = 1'b0;
    if8.IVALID = 1'b0;
    #1 check({tag, "_ovalid_c1"}, get_ovalid(w6), 0);
    @(negedge clk);
    #1 check({tag, "_ovalid_c2"}, get_ovalid(w6), 0);
    @(negedge clk);
    #1 check({tag, "_ovalid_c3"}, get_ovalid(w6), 1);
    check({tag, "_odata"}, get_odata(w6), exp);
  endtask

  initial begin
    rst_n = 1'b0;
    if8.IVALID = 1'b0; if8.IDATA = '0; if8.N_SHIFT = '0; if8.ARITH = 1'b0; if8.OREADY = 1'b1;
    if6.IVALID = 1'b0; if6.IDATA = '0; if6.N_SHIFT = '0; if6.ARITH = 1'b0; if6.OREADY = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_ovalid", 32'(if8.OVALID), 0);
    check("rst_odata",  32'(if8.ODATA),  0);
    check("rst_iready", 32'(if8.IREADY), 1);
    check("rst_iready6", 32'(if6.IREADY), 1);

    // Logical / arithmetic / zero shift on the 8-bit instance
    lat_run(1'b0, 'hB4, 3, 1'b0, 'h16, "log_b4_3");
    lat_run(1'b0, 'hB4, 7, 1'b0, 'h01, "log_b4_7");
    lat_run(1'b0, 'hB4, 3, 1'b1, 'hF6, "ari_b4_3");
    lat_run(1'b0, 'h74, 3, 1'b1, 'h0E, "ari_74_3");
    lat_run(1'b0, 'h5A, 0, 1'b1, 'h5A, "ari_5a_0");
    lat_run(1'b0, 'hA5, 0, 1'b0, 'hA5, "log_a5_0");

    // Streaming: 8 back-to-back words, outputs 3 cycles later with no bubbles
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 8) begin
        if8.IVALID = 1'b1; if8.IDATA = 8'(8'h80 + c); if8.N_SHIFT = 3'd1; if8.ARITH = 1'b0;
      end else begin
        if8.IVALID = 1'b0;
      end
      #1;
      if (c < 8) check("stream_iready", 32'(if8.IREADY), 1);
      if (c < 3) check("stream_empty", 32'(if8.OVALID), 0);
      else begin
        check("stream_ovalid", 32'(if8.OVALID), 1);
        check("stream_odata", 32'(if8.ODATA), 32'(stream_exp[c-3]));
      end
    end

    // Backpressure: OREADY low, 5 words offered, only 3 fit
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if8.OREADY  = 1'b0;
      if8.IVALID  = (idx < 5);
      if8.IDATA   = bp_in[(idx < 5) ? idx : 4];
      if8.N_SHIFT = 3'd4;
      if8.ARITH   = 1'b0;
      #1;
      if (c >= 3) begin
        check("bp_hold_ovalid", 32'(if8.OVALID), 1);
        check("bp_hold_odata", 32'(if8.ODATA), 'h01);
        check("bp_iready_low", 32'(if8.IREADY), 0);
      end
      if (if8.IVALID && if8.IREADY) idx++;
    end
    check("bp_accepted", idx, 3);

    // Release backpressure: all 5 drain in order
    outc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if8.OREADY = 1'b1;
      if8.IVALID = (idx < 5);
      if8.IDATA  = bp_in[(idx < 5) ? idx : 4];
      #1;
      if (if8.OVALID) begin
        if (outc < 5) check("bp_out", 32'(if8.ODATA), 32'(bp_exp[outc]));
        outc++;
      end
      if (if8.IVALID && if8.IREADY) idx++;
    end
    check("bp_out_count", outc, 5);
    check("bp_in_count", idx, 5);
    check("bp_drained", 32'(if8.OVALID), 0);

    // Reset mid-flight
    @(negedge clk);
    if8.OREADY = 1'b0; if8.IVALID = 1'b1; if8.IDATA = 8'hFF; if8.N_SHIFT = 3'd0; if8.ARITH = 1'b0;
    @(negedge clk);
    if8.IDATA = 8'h3C; if8.N_SHIFT = 3'd2;
    @(negedge clk);
    if8.IVALID = 1'b0;
    @(negedge clk);
    #1;
    check("mid_pre_ovalid", 32'(if8.OVALID), 1);
    check("mid_pre_odata", 32'(if8.ODATA), 'hFF);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ovalid", 32'(if8.OVALID), 0);
    check("mid_rst_odata", 32'(if8.ODATA), 0);
    check("mid_rst_iready", 32'(if8.IREADY), 1);
    @(negedge clk);
    rst_n = 1'b1;
    if8.OREADY = 1'b1;
    #1 check("mid_post_iready", 32'(if8.IREADY), 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 check("mid_no_stale", 32'(if8.OVALID), 0);
    end

    // First word after reset keeps the normal latency
    lat_run(1'b0, 'hC3, 2, 1'b1, 'hF0, "post_rst_c3_2");

    // Non-power-of-2 width: saturation to fill bits
    lat_run(1'b1, 'h3F, 7, 1'b0, 'h00, "w6_log_3f_7");
    lat_run(1'b1, 'h3F, 7, 1'b1, 'h3F, "w6_ari_3f_7");
    lat_run(1'b1, 'h20, 6, 1'b1, 'h3F, "w6_ari_20_6");
    lat_run(1'b1, 'h2C, 5, 1'b0, 'h01, "w6_log_2c_5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
